muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: single-cycle multiplier behind a
// one-state pipeline, and an iterative restoring divider with sign fix-up.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    localparam int unsigned     CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, result_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_quo_q, neg_rem_q;

    logic            accept, div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        accept      = in_valid && (state_q == IDLE) && !flush;
        div_signed  = !funct3[0];
        a_neg       = div_signed && op_a[XLEN-1];
        b_neg       = div_signed && op_b[XLEN-1];
        div_zero    = (op_b == '0);
        div_ovf     = div_signed && (op_a == MOST_NEG) && (op_b == '1);
        special_res = div_zero ? (funct3[1] ? op_a : '1)
                               : (funct3[1] ? '0   : op_a);
    end

    // Sign-extend to 2*XLEN so the truncated product is exact for all sign mixes
    logic                mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0]   a_ext, b_ext, prod;
    logic [XLEN-1:0]     mul_res;

    always_comb begin
        mul_a_sgn = (op_q == 2'b01) || (op_q == 2'b10);
        mul_b_sgn = (op_q == 2'b01);
        a_ext     = {{XLEN{mul_a_sgn && a_q[XLEN-1]}}, a_q};
        b_ext     = {{XLEN{mul_b_sgn && b_q[XLEN-1]}}, b_q};
        prod      = a_ext * b_ext;
        mul_res   = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // a_q holds the dividend bits shifting out and the quotient bits shifting in
    logic [XLEN:0]   rem_shift;
    logic            take;
    logic [XLEN-1:0] rem_step, quo_step, fix_res;

    always_comb begin
        rem_shift = {rem_q, a_q[XLEN-1]};
        take      = (rem_shift >= {1'b0, b_q});
        rem_step  = take ? XLEN'(rem_shift - {1'b0, b_q}) : rem_shift[XLEN-1:0];
        quo_step  = {a_q[XLEN-2:0], take};
        fix_res   = op_q[1] ? (neg_rem_q ? -rem_q : rem_q)
                            : (neg_quo_q ? -a_q  : a_q);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                if (!funct3[2])             state_d = MUL;
                else if (div_zero || div_ovf) state_d = DONE;
                else                        state_d = DIV;
            end
            MUL:  state_d = DONE;
            DIV:  if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = (state_q != IDLE);
        out_valid  = (state_q == DONE);
        out_result = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q  <= funct3[1:0];
                    cnt_q <= '0;
                    rem_q <= '0;
                    if (funct3[2]) begin
                        a_q       <= a_neg ? -op_a : op_a;
                        b_q       <= b_neg ? -op_b : op_b;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (div_zero || div_ovf) result_q <= special_res;
                    end else begin
                        a_q <= op_a;
                        b_q <= op_b;
                    end
                end
                MUL: if (!flush) result_q <= mul_res;
                DIV: begin
                    a_q   <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: if (!flush) result_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at XLEN=32, with hand-written
// sequences for back-pressure, flush, reset and re-accept corner cases.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                           F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                           F_REM = 3'b110, F_REMU = 3'b111;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b, out_result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Present a request at a negedge; return just after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy);
        @(negedge clk);
        in_valid  = 1'b1;
        funct3    = f;
        op_a      = a;
        op_b      = b;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct3   = 3'b011;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0000_0000;
    endtask

    // Count cycles after the accept edge until out_valid is seen (bounded)
    task automatic wait_result(input string name, input logic [31:0] exp, input int lat_exp);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check($sformatf("%s latency", name), 32'(lat), 32'(lat_exp));
        check($sformatf("%s result", name), out_result, exp);
    endtask

    task automatic consume(input string name, input logic [31:0] exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s idle out_valid", name), {31'b0, out_valid}, 32'd0);
        check($sformatf("%s idle in_ready", name), {31'b0, in_ready}, 32'd1);
        check($sformatf("%s held result", name), out_result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen_valid;

        vecs[0]  = '{F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
        vecs[1]  = '{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2};
        vecs[2]  = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vecs[3]  = '{F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vecs[4]  = '{F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
        vecs[5]  = '{F_MUL,    32'd3,        32'd4,        32'd12,       2};
        vecs[6]  = '{F_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
        vecs[7]  = '{F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[8]  = '{F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[9]  = '{F_DIVU,   32'd100,      32'd7,        32'd14,       34};
        vecs[10] = '{F_REMU,   32'd100,      32'd7,        32'd2,        34};
        vecs[11] = '{F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[12] = '{F_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[13] = '{F_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
        vecs[14] = '{F_REMU,   32'hFFFFFFFF, 32'h10,       32'hF,        34};
        vecs[15] = '{F_DIV,    32'h80000000, 32'd1,        32'h80000000, 34};
        vecs[16] = '{F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[17] = '{F_REM,    32'd5,        32'd0,        32'd5,        1};
        vecs[18] = '{F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[19] = '{F_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, 1'b1);
            wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
            consume($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-pressure in DONE, then a request arriving alongside out_ready
        issue(F_DIVU, 32'd100, 32'd7, 1'b0);
        wait_result("hold", 32'd14, 34);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold%0d result", k), out_result, 32'd14);
            check($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1; funct3 = F_MUL; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        check("done-no-accept busy", {31'b0, busy}, 32'd0);
        check("done-no-accept in_ready", {31'b0, in_ready}, 32'd1);
        check("done-no-accept out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = 32'hDEAD_BEEF;
        wait_result("reaccept", 32'd12, 2);
        consume("reaccept", 32'd12);

        // Flush mid-divide
        issue(F_DIVU, 32'd100, 32'd7, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush held result", out_result, 32'd12);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check("flush no result", {31'b0, seen_valid}, 32'd0);
        issue(F_MUL, 32'd3, 32'd4, 1'b1);
        wait_result("after-flush mul", 32'd12, 2);
        consume("after-flush mul", 32'd12);

        // Reset mid-MUL
        issue(F_MUL, 32'd3, 32'd5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst-mul out_valid", {31'b0, out_valid}, 32'd0);
        check("rst-mul busy", {31'b0, busy}, 32'd0);
        check("rst-mul in_ready", {31'b0, in_ready}, 32'd1);
        check("rst-mul out_result", out_result, 32'd0);
        rst = 1'b0;

        // Reset while in DONE, with flush also asserted
        issue(F_DIVU, 32'd5, 32'd0, 1'b0);
        wait_result("rst-done setup", 32'hFFFFFFFF, 1);
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst-done out_valid", {31'b0, out_valid}, 32'd0);
        check("rst-done busy", {31'b0, busy}, 32'd0);
        check("rst-done out_result", out_result, 32'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Flush together with a request in IDLE
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct3 = F_MUL; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        check("flush-idle busy", {31'b0, busy}, 32'd0);
        check("flush-idle in_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("flush-idle busy2", {31'b0, busy}, 32'd0);
        check("flush-idle out_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
